// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer.
// Mode encodings and the select-width helper live here so every file agrees on them.
package rr_mux_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between producers, the arbiter and the single consumer.
// master = the side that drives data/valid in and out_ready; slave = the arbiter.
interface rr_mux_arb_if
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );

endinterface

// File: rtl/rr_mux_arb_grant.sv
// Combinational grant picker: one-hot grant plus encoded index from a request vector.
// Round-robin search uses a doubled request vector so the wrap needs no rotator.
module rr_grant_n
    import rr_mux_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [NUM_CH-1:0]   mask;
    logic [2*NUM_CH-1:0] dbl_req;
    logic [2*NUM_CH-1:0] lowest;

    // Lower half keeps only channels at or above ptr; upper half is the full
    // request set, so a miss in the lower half wraps around to channel 0.
    // Fixed mode clears the mask, leaving the plain 0..NUM_CH-1 order.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
            assign mask[gi] = mode & (SEL_W'(gi) >= ptr);
        end
    endgenerate

    assign dbl_req = {req, req & mask};
    assign lowest  = dbl_req & (-dbl_req);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fold
            assign grant[gi] = lowest[gi] | lowest[gi + NUM_CH];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel arbitrated multiplexer with a one-deep registered output stage.
// Holds the winning item until the consumer takes it; round-robin or fixed priority.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int MODE   = ARB_RR
) (
    input  logic          clk,
    input  logic          rst,
    rr_mux_arb_if.slave   bus
);

    localparam int SEL_W = clog2(NUM_CH);

    logic [WIDTH-1:0]  out_data_reg;
    logic [WIDTH-1:0]  out_data_next;
    logic [SEL_W-1:0]  out_sel_reg;
    logic [SEL_W-1:0]  out_sel_next;
    logic              out_valid_reg;
    logic              out_valid_next;
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  ptr_next;

    logic              load_en;
    logic              xfer;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  ch_data [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_grant_n #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_grant (
        .req       (bus.in_valid),
        .ptr       (ptr_reg),
        .mode      (MODE == ARB_RR),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The output slot is free when empty or when it is being drained this cycle.
    assign load_en      = ~out_valid_reg | bus.out_ready;
    assign bus.in_ready = rst ? '0 : (grant & {NUM_CH{load_en}});
    assign xfer         = |bus.in_ready;

    always_comb begin
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (xfer) begin
            out_data_next  = ch_data[grant_idx];
            out_sel_next   = grant_idx;
            out_valid_next = 1'b1;
            if (MODE == ARB_RR) begin
                ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised N-channel, W-bit arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the successor to the single-bit 2:1 select mux: instead of an external select it picks a winner among requesting channels, using fixed-priority or round-robin mode, and holds the result until the consumer accepts it. It is used wherever several producers share one datapath, for example instruction/data memory port sharing and writeback source merging.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- NUM_CH, 4, number of input channels (≥2; need not be a power of two)
- MODE, 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin
- SEL_W, derived as clog2(NUM_CH); not overridable

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_CH  channel i has data
- in_ready  out  NUM_CH  channel i's data is taken this cycle (one-hot or zero)
- out_data  out  WIDTH  registered winning data
- out_sel  out  SEL_W  index of channel that produced out_data
- out_valid  out  1  out_data/out_sel hold an unconsumed item
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- load_en = ~out_valid | out_ready. The output register can accept an item when it is empty or is being drained in the same cycle.
- Grant (combinational): the highest-priority channel with in_valid=1 wins. Fixed mode uses order 0..NUM_CH-1. Round-robin mode starts the search at ptr and wraps modulo NUM_CH.
- in_ready[i] = grant[i] & load_en. At most one bit is set, and no bit is set when no channel is valid.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On that edge: out_data ← channel i data, out_sel ← i, out_valid ← 1.
- Drain without refill (out_ready=1, no channel valid): out_valid ← 0. out_data and out_sel keep their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and out_valid are frozen. All in_ready bits are 0.
- Round-robin pointer ptr (SEL_W bits):
  - On a transfer from channel i, ptr ← (i+1) mod NUM_CH. When i = NUM_CH-1, ptr wraps to 0.
  - ptr changes only on a transfer.
  - In fixed mode ptr is held at 0 and ignored.
- Inputs may change while not granted. The block makes no assumption that in_valid stays asserted.
- A channel that withdraws in_valid before it is granted is simply skipped.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready all 0 during the rst cycle.
- rst has priority over every other event, including a transfer or drain in the same cycle. Reset during a stall discards the held item.
- Latency: input accepted at edge k is visible on out_data/out_valid immediately after edge k (one-cycle registered path).
- Throughput: one item per cycle when out_ready is held at 1. Back-to-back accept and drain happen in the same cycle.
- Dependency paths: in_ready depends combinationally on in_valid, out_valid, out_ready and ptr. out_* are pure register outputs with no combinational path from inputs.
- Fairness: in round-robin mode, under continuous requests on all channels, each channel is granted exactly once every NUM_CH transfers.

## Structure
- Shared package/header holds the mode constants ARB_FIXED=0 and ARB_RR=1, plus a clog2 helper function used for SEL_W.
- Sub-module rr_grant_n (combinational) maps (req[NUM_CH], ptr, mode) to a one-hot grant[NUM_CH] and an encoded grant_idx[SEL_W].
  - Round-robin search is implemented by double-width request masking, not by a barrel rotate.
  - Verified standalone.
- Top level contains the output register, the pointer register and the load_en/in_ready logic only.

## Test plan
- Reset and idle: assert rst with in_valid=4'b1111 for 2 cycles. Required: out_valid=0, out_data=0, out_sel=0, in_ready=0. Release rst with all in_valid=0: outputs stay idle.
- Round-robin rotation (MODE=1, NUM_CH=4, WIDTH=16): channels i drive data 16'hA000+i, all valid, out_ready=1 for 8 cycles. Required: out_sel sequence is 0,1,2,3,0,1,2,3 with matching data, and ptr wraps to 0 after channel 3.
- Fixed priority (MODE=0): in_valid=4'b1010 held for 3 cycles with out_ready=1. Required: channel 1 is granted every cycle, out_sel=1 each cycle, in_ready=4'b0010.
- Backpressure: load one item from channel 2 (data 16'h1234), then hold out_ready=0 for 3 cycles with channel 3 valid. Required: out_data stays 16'h1234, out_sel=2, in_ready=0 throughout. Raise out_ready: on the same edge out_data becomes channel 3's data and out_sel=3.
- Drain without refill: out_valid=1, out_ready=1, all in_valid=0. Required: out_valid=0 next cycle, out_data unchanged, ptr unchanged.
- Odd NUM_CH=3 with reset mid-operation: alternate requests on channels 0 and 2 and assert rst while out_valid=1 and out_ready=0. Required: next cycle out_valid=0 and ptr=0. Non-power-of-two wrap runs 2→0 and never produces out_sel=3.
